key_event: RTL and testbench

//  Turns a debounced key level into single-cycle event pulses: press, release, click, double-click, long and auto-repeat.

---
 rtl/key_event_pkg.sv | 22 ++
 rtl/key_event.sv | 144 ++++++++++++++
 tb/tb_key_event.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/key_event_pkg.sv
// Shared definitions for the key event detector: state encoding, key polarity
// constants and a small helper used to size the shared timer.
package key_event_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_WAIT2  = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_t;

    localparam logic KEY_ACT_HIGH = 1'b1;
    localparam logic KEY_ACT_LOW  = 1'b0;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/key_event.sv
// Turns a debounced key level into single-cycle press/release/click/dclick/long/repeat pulses.
// Latency: 2 clocks from key_i change to event pulse; no backpressure, pulses are fire-and-forget.
module key_event
    import key_event_pkg::*;
#(
    parameter logic KEY_ACTIVE = KEY_ACT_HIGH,
    parameter int   LONG_CNT   = 50_000_000,
    parameter int   DCLICK_CNT = 12_500_000,
    parameter int   REPEAT_CNT = 5_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_i,
    output logic key_press,
    output logic key_release,
    output logic key_click,
    output logic key_dclick,
    output logic key_long,
    output logic key_repeat,
    output logic key_hold
);

    localparam int CNT_W = $clog2(max3(LONG_CNT, DCLICK_CNT, REPEAT_CNT) + 1);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CNT - 1);
    localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CNT - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'((REPEAT_CNT > 0) ? REPEAT_CNT - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    if (LONG_CNT < 2) begin : g_bad_long
        $error("key_event: LONG_CNT must be >= 2");
    end
    if (DCLICK_CNT < 2) begin : g_bad_dclick
        $error("key_event: DCLICK_CNT must be >= 2");
    end

    logic             key_q;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, release_q, click_q, dclick_q, long_q, repeat_q, hold_q;
    logic             press_d, release_d, click_d, dclick_d, long_d, repeat_d;

    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        dclick_d  = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (key_q) begin
                    state_d = ST_PRESS1;
                    press_d = 1'b1;
                end
            end
            ST_PRESS1: begin
                if (!key_q) begin
                    state_d   = ST_WAIT2;
                    release_d = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = ST_LONG;
                    long_d  = 1'b1;
                end
            end
            ST_WAIT2: begin
                // A second press wins over the window timeout in the same cycle.
                if (key_q) begin
                    state_d = ST_PRESS2;
                    press_d = 1'b1;
                end else if (cnt_q == DCLICK_LAST) begin
                    state_d = ST_IDLE;
                    click_d = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (!key_q) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                    dclick_d  = 1'b1;
                end else if (cnt_q == LONG_LAST) begin
                    // The first short press is still reported before going long.
                    state_d = ST_LONG;
                    click_d = 1'b1;
                    long_d  = 1'b1;
                end
            end
            ST_LONG: begin
                if (!key_q) begin
                    state_d   = ST_IDLE;
                    release_d = 1'b1;
                end else if ((REPEAT_CNT > 0) && (cnt_q == REPEAT_LAST)) begin
                    repeat_d = 1'b1;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            key_q     <= 1'b0;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
            click_q   <= 1'b0;
            dclick_q  <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            hold_q    <= 1'b0;
        end else begin
            key_q     <= (key_i == KEY_ACTIVE);
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            press_q   <= press_d;
            release_q <= release_d;
            click_q   <= click_d;
            dclick_q  <= dclick_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            hold_q    <= (state_d == ST_PRESS1) || (state_d == ST_PRESS2) || (state_d == ST_LONG);
        end
    end

    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_click   = click_q;
    assign key_dclick  = dclick_q;
    assign key_long    = long_q;
    assign key_repeat  = repeat_q;
    assign key_hold    = hold_q;

endmodule

// File: tb/tb_key_event.sv
// Bench for key_event: timestamp-based event model checked every cycle against an
// active-high and an active-low instance, plus directed pulse-count checks per scenario.
module tb_key_event;

    localparam int LONG   = 20;
    localparam int DCLICK = 10;
    localparam int REP    = 5;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic key = 1'b0;
    logic key_n;

    logic a_press, a_release, a_click, a_dclick, a_long, a_repeat, a_hold;
    logic b_press, b_release, b_click, b_dclick, b_long, b_repeat, b_hold;

    assign key_n = ~key;

    always #5 clk = ~clk;

    key_event #(.KEY_ACTIVE(1'b1), .LONG_CNT(LONG), .DCLICK_CNT(DCLICK), .REPEAT_CNT(REP)) dut_hi (
        .clk(clk), .rst(rst), .key_i(key),
        .key_press(a_press), .key_release(a_release), .key_click(a_click),
        .key_dclick(a_dclick), .key_long(a_long), .key_repeat(a_repeat), .key_hold(a_hold)
    );

    key_event #(.KEY_ACTIVE(1'b0), .LONG_CNT(LONG), .DCLICK_CNT(DCLICK), .REPEAT_CNT(REP)) dut_lo (
        .clk(clk), .rst(rst), .key_i(key_n),
        .key_press(b_press), .key_release(b_release), .key_click(b_click),
        .key_dclick(b_dclick), .key_long(b_long), .key_repeat(b_repeat), .key_hold(b_hold)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: what the key has done, tracked as timestamps.
    logic lvl       = 1'b0;
    logic held      = 1'b0;
    logic long_mode = 1'b0;
    int   shorts    = 0;
    int   t_press   = 0;
    int   t_rel     = 0;
    int   t_rep     = 0;
    logic [6:0] exp_v = '0;

    int c_press, c_release, c_click, c_dclick, c_long, c_repeat;

    task automatic model_step(input logic rst_s, input logic key_s);
        logic pr, rl, ck, dc, lg, rp;
        pr = 0; rl = 0; ck = 0; dc = 0; lg = 0; rp = 0;
        if (rst_s) begin
            held = 0; long_mode = 0; shorts = 0; lvl = 0;
        end else begin
            if (!held) begin
                if (lvl) begin
                    pr = 1; held = 1; t_press = cyc;
                end else if (shorts == 1 && cyc - t_rel == DCLICK) begin
                    ck = 1; shorts = 0;
                end
            end else begin
                if (!lvl) begin
                    rl = 1; held = 0; t_rel = cyc;
                    if (long_mode) begin
                        long_mode = 0; shorts = 0;
                    end else if (shorts == 1) begin
                        dc = 1; shorts = 0;
                    end else begin
                        shorts = 1;
                    end
                end else if (!long_mode && cyc - t_press == LONG) begin
                    lg = 1; ck = (shorts == 1); shorts = 0; long_mode = 1; t_rep = cyc;
                end else if (long_mode && REP > 0 && cyc - t_rep == REP) begin
                    rp = 1; t_rep = cyc;
                end
            end
            lvl = key_s;
        end
        exp_v = {pr, rl, ck, dc, lg, rp, held};
    endtask

    task automatic check_vec(input string tag, input logic [6:0] obs, input logic [6:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
        end
    endtask

    task automatic check_cnt(input string tag, input int obs, input int expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic clr_counts();
        c_press = 0; c_release = 0; c_click = 0; c_dclick = 0; c_long = 0; c_repeat = 0;
    endtask

    task automatic tick();
        logic rst_s, key_s;
        @(posedge clk);
        rst_s = rst;
        key_s = key;
        cyc++;
        model_step(rst_s, key_s);
        #1;
        check_vec("ev_hi", {a_press, a_release, a_click, a_dclick, a_long, a_repeat, a_hold}, exp_v);
        check_vec("ev_lo", {b_press, b_release, b_click, b_dclick, b_long, b_repeat, b_hold}, exp_v);
        c_press   += int'(a_press);
        c_release += int'(a_release);
        c_click   += int'(a_click);
        c_dclick  += int'(a_dclick);
        c_long    += int'(a_long);
        c_repeat  += int'(a_repeat);
    endtask

    task automatic drive(input logic lvl_in, input int n);
        key = lvl_in;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        clr_counts();
        rst = 1'b1;
        drive(1'b0, 3);
        rst = 1'b0;
        drive(1'b0, 3);

        // Single click
        clr_counts();
        drive(1'b1, 6);
        drive(1'b0, 16);
        check_cnt("s1_press", c_press, 1);
        check_cnt("s1_click", c_click, 1);
        check_cnt("s1_dclick", c_dclick, 0);

        // Double click
        clr_counts();
        drive(1'b1, 4);
        drive(1'b0, 4);
        drive(1'b1, 4);
        drive(1'b0, 16);
        check_cnt("s2_press", c_press, 2);
        check_cnt("s2_release", c_release, 2);
        check_cnt("s2_dclick", c_dclick, 1);
        check_cnt("s2_click", c_click, 0);

        // Long hold with repeats
        clr_counts();
        drive(1'b1, 50);
        drive(1'b0, 16);
        check_cnt("s3_long", c_long, 1);
        check_cnt("s3_repeat", c_repeat, 5);
        check_cnt("s3_click", c_click + c_dclick, 0);

        // Second press lands exactly on the last window cycle
        clr_counts();
        drive(1'b1, 4);
        drive(1'b0, 10);
        drive(1'b1, 4);
        drive(1'b0, 16);
        check_cnt("s4a_click", c_click, 0);
        check_cnt("s4a_dclick", c_dclick, 1);

        // One cycle later: window has expired, new single press
        clr_counts();
        drive(1'b1, 4);
        drive(1'b0, 11);
        drive(1'b1, 4);
        drive(1'b0, 16);
        check_cnt("s4b_click", c_click, 2);
        check_cnt("s4b_dclick", c_dclick, 0);

        // Reset in the middle of a long hold, key kept pressed
        drive(1'b1, 30);
        rst = 1'b1;
        drive(1'b1, 3);
        rst = 1'b0;
        clr_counts();
        drive(1'b1, 25);
        check_cnt("s5_press", c_press, 1);
        check_cnt("s5_long", c_long, 1);
        drive(1'b0, 16);

        // Random key activity with run lengths spanning all timer windows
        for (int r = 0; r < 60; r++) begin
            drive(1'($urandom_range(0, 1)), int'($urandom_range(1, 28)));
            if ($urandom_range(0, 29) == 0) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
        end
        drive(1'b0, 16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
